// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control-unit <-> PC sequencer bundle.
interface pc_sequencer_if #(
    parameter int D = 12,
    parameter int A = 8
);
    logic         start;
    logic         stall;
    logic         branch;
    logic [A-1:0] branch_sel;
    logic         halt;
    logic         cfg_we;
    logic [A-1:0] cfg_idx;
    logic [D-1:0] cfg_off;
    logic [D-1:0] pc;
    logic         running;
    logic         done;
    logic         bad_sel;

    modport master (
        output start, stall, branch, branch_sel, halt, cfg_we, cfg_idx, cfg_off,
        input  pc, running, done, bad_sel
    );

    modport slave (
        input  start, stall, branch, branch_sel, halt, cfg_we, cfg_idx, cfg_off,
        output pc, running, done, bad_sel
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with IDLE/RUN/HALT control and a writable branch-offset table.
module pc_sequencer #(
    parameter int           D        = 12,
    parameter int           A        = 8,
    parameter int           DEPTH    = 4,
    parameter logic [D-1:0] START_PC = '0,
    parameter logic [D-1:0] END_PC   = '1
) (
    input logic          clk,
    input logic          reset_n,
    pc_sequencer_if.slave s
);
    localparam int           IW      = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [A-1:0] DEPTH_A = A'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t       state;
    logic [D-1:0] tbl [DEPTH];
    logic         sel_ok;
    logic [D-1:0] off;

    function automatic logic [D-1:0] init_off(int i);
        return i == 0 ? D'(-5) : i == 1 ? D'(20) : i == 2 ? D'(-1) : '0;
    endfunction

    // Out-of-range selects contribute a zero offset, so the PC holds.
    always_comb begin
        sel_ok = s.branch_sel < DEPTH_A;
        off    = sel_ok ? tbl[s.branch_sel[IW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            s.pc      <= START_PC;
            s.running <= 1'b0;
            s.done    <= 1'b0;
            s.bad_sel <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl[i] <= init_off(i);
        end else begin
            s.bad_sel <= 1'b0;
            if (s.cfg_we && s.cfg_idx < DEPTH_A) tbl[s.cfg_idx[IW-1:0]] <= s.cfg_off;
            case (state)
                IDLE, HALT: begin
                    if (s.start) begin
                        state     <= RUN;
                        s.pc      <= START_PC;
                        s.running <= 1'b1;
                        s.done    <= 1'b0;
                    end
                end
                RUN: begin
                    if (s.halt || (!s.stall && !s.branch && s.pc == END_PC)) begin
                        state     <= HALT;
                        s.running <= 1'b0;
                        s.done    <= 1'b1;
                    end else if (!s.stall && s.branch) begin
                        s.pc      <= s.pc + off;
                        s.bad_sel <= !sel_ok;
                    end else if (!s.stall) begin
                        s.pc <= s.pc + D'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    s.running <= 1'b0;
                    s.done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (default END_PC and END_PC=6 instances).
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    pc_sequencer_if #(.D(12), .A(8)) b0 ();
    pc_sequencer_if #(.D(12), .A(8)) b1 ();

    pc_sequencer u0 (.clk(clk), .reset_n(reset_n), .s(b0));
    pc_sequencer #(.END_PC(12'd6)) u1 (.clk(clk), .reset_n(reset_n), .s(b1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected pc, then compare after the edge.
    task automatic cyc(input bit u, input logic st, input logic hl, input logic stl,
                       input logic br, input logic [7:0] sel, input logic we,
                       input logic [7:0] idx, input logic [11:0] off, input logic [11:0] exp_pc);
        logic [11:0] want;
        logic [11:0] got;
        if (u) begin
            b1.start = st; b1.halt = hl; b1.stall = stl; b1.branch = br; b1.branch_sel = sel;
            b1.cfg_we = we; b1.cfg_idx = idx; b1.cfg_off = off;
        end else begin
            b0.start = st; b0.halt = hl; b0.stall = stl; b0.branch = br; b0.branch_sel = sel;
            b0.cfg_we = we; b0.cfg_idx = idx; b0.cfg_off = off;
        end
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = u ? b1.pc : b0.pc;
        check("pc", got, want);
        if (u) begin
            b1.start = 0; b1.halt = 0; b1.stall = 0; b1.branch = 0; b1.cfg_we = 0;
        end else begin
            b0.start = 0; b0.halt = 0; b0.stall = 0; b0.branch = 0; b0.cfg_we = 0;
        end
    endtask

    task automatic step(input bit u, input logic [11:0] e);
        cyc(u, 0, 0, 0, 0, 8'd0, 0, 8'd0, 12'd0, e);
    endtask

    task automatic start(input bit u, input logic [11:0] e);
        cyc(u, 1, 0, 0, 0, 8'd0, 0, 8'd0, 12'd0, e);
    endtask

    task automatic brn(input logic [7:0] sel, input logic [11:0] e);
        cyc(0, 0, 0, 0, 1, sel, 0, 8'd0, 12'd0, e);
    endtask

    initial begin
        b0.start = 0; b0.halt = 0; b0.stall = 0; b0.branch = 0; b0.branch_sel = 0;
        b0.cfg_we = 0; b0.cfg_idx = 0; b0.cfg_off = 0;
        b1.start = 0; b1.halt = 0; b1.stall = 0; b1.branch = 0; b1.branch_sel = 0;
        b1.cfg_we = 0; b1.cfg_idx = 0; b1.cfg_off = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", b0.pc, 0);
        check("rst_running", b0.running, 0);
        check("rst_done", b0.done, 0);
        check("rst_bad_sel", b0.bad_sel, 0);
        reset_n = 1'b1;

        start(0, 12'd0);
        check("run_running", b0.running, 1);
        check("run_done", b0.done, 0);
        for (int i = 1; i <= 10; i++) step(0, 12'(i));

        brn(8'd0, 12'd5);
        brn(8'd1, 12'd25);
        brn(8'd2, 12'd24);
        brn(8'd3, 12'd24);
        check("sel3_bad_sel", b0.bad_sel, 0);

        cyc(0, 0, 1, 0, 0, 8'd0, 0, 8'd0, 12'd0, 12'd24);
        check("halt_done", b0.done, 1);
        start(0, 12'd0);
        step(0, 12'd1);
        step(0, 12'd2);
        brn(8'd0, 12'hFFD);
        brn(8'd7, 12'hFFD);
        check("bad_sel_pulse", b0.bad_sel, 1);
        step(0, 12'hFFE);
        check("bad_sel_clear", b0.bad_sel, 0);
        step(0, 12'hFFF);
        step(0, 12'hFFF);
        check("end_done", b0.done, 1);
        check("end_running", b0.running, 0);

        start(0, 12'd0);
        check("restart_done", b0.done, 0);
        for (int i = 1; i <= 3; i++) step(0, 12'(i));
        cyc(0, 0, 0, 1, 1, 8'd1, 0, 8'd0, 12'd0, 12'd3);
        cyc(0, 0, 1, 0, 1, 8'd1, 0, 8'd0, 12'd0, 12'd3);
        check("halt_br_done", b0.done, 1);
        check("halt_br_running", b0.running, 0);
        brn(8'd1, 12'd3);
        step(0, 12'd3);
        start(0, 12'd0);
        check("start2_running", b0.running, 1);
        check("start2_done", b0.done, 0);

        for (int i = 1; i <= 8; i++) step(0, 12'(i));
        cyc(0, 0, 0, 0, 1, 8'd1, 1, 8'd1, 12'hFFD, 12'd28);
        brn(8'd1, 12'd25);
        cyc(0, 0, 0, 0, 0, 8'd0, 1, 8'd9, 12'h100, 12'd26);
        brn(8'd1, 12'd23);
        start(0, 12'd24);
        cyc(0, 0, 1, 0, 0, 8'd0, 0, 8'd0, 12'd0, 12'd24);
        start(0, 12'd0);
        for (int i = 1; i <= 4; i++) step(0, 12'(i));

        #2 reset_n = 1'b0;
        #1;
        check("async_pc", b0.pc, 0);
        check("async_running", b0.running, 0);
        check("async_done", b0.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        start(0, 12'd0);
        brn(8'd1, 12'd20);

        start(1, 12'd0);
        for (int i = 1; i <= 6; i++) step(1, 12'(i));
        step(1, 12'd6);
        check("u1_done", b1.done, 1);
        check("u1_running", b1.running, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
